// File: rtl/result_mux_skid.sv
// N-way WIDTH-bit result select with a registered output stage and a 2-entry
// skid buffer so the register-file write port can stall without losing beats.
module result_mux_skid #(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic             err;
  } beat_t;

  beat_t out_q, out_d;
  beat_t skid_q, skid_d;
  beat_t new_beat;
  logic  out_valid_q, out_valid_d;
  logic  skid_valid_q, skid_valid_d;
  logic  in_ready_q, in_ready_d;
  logic  sel_hit;
  logic  accept;
  logic  out_free;

  assign accept   = in_valid && in_ready_q;
  assign out_free = !out_valid_q || out_ready;

  // Selects with no matching source deliver zero data flagged as an error.
  always_comb begin
    new_beat      = '0;
    sel_hit       = 1'b0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        new_beat.data = in_data[k*WIDTH +: WIDTH];
        sel_hit       = 1'b1;
      end
    end
    new_beat.sel = in_sel;
    new_beat.err = !sel_hit;
  end

  // The skid entry always holds the older beat, so it takes the output
  // register before any beat accepted on the same edge.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (out_free && skid_valid_q) begin
      out_d        = skid_q;
      out_valid_d  = 1'b1;
      skid_valid_d = accept;
      if (accept) begin
        skid_d = new_beat;
      end
    end else if (out_free && accept) begin
      out_d       = new_beat;
      out_valid_d = 1'b1;
    end else if (out_free) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      skid_d       = new_beat;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_q.data;
  assign out_sel   = out_q.sel;
  assign out_err   = out_q.err;

endmodule

// File: tb/tb_result_mux_skid.sv
// Directed checks on a 4-way and a 3-way selector, plus random sweeps of
// several width/depth configurations scored against an in-order beat queue.
module tb_result_mux_skid;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Directed DUT A: WIDTH=32, NUM_IN=4
  logic         rst0;
  logic [127:0] a_data;
  logic [1:0]   a_sel, a_os;
  logic         a_iv, a_ir, a_oe, a_ov, a_or;
  logic [31:0]  a_od;

  result_mux_skid #(.WIDTH(32), .NUM_IN(4)) dut_a (
    .clk(clk), .rst(rst0), .in_data(a_data), .in_sel(a_sel), .in_valid(a_iv),
    .in_ready(a_ir), .out_data(a_od), .out_sel(a_os), .out_err(a_oe),
    .out_valid(a_ov), .out_ready(a_or)
  );

  // Directed DUT B: WIDTH=32, NUM_IN=3 (select value 3 is out of range)
  logic [95:0]  b_data;
  logic [1:0]   b_sel, b_os;
  logic         b_iv, b_ir, b_oe, b_ov, b_or;
  logic [31:0]  b_od;

  result_mux_skid #(.WIDTH(32), .NUM_IN(3)) dut_b (
    .clk(clk), .rst(rst0), .in_data(b_data), .in_sel(b_sel), .in_valid(b_iv),
    .in_ready(b_ir), .out_data(b_od), .out_sel(b_os), .out_err(b_oe),
    .out_valid(b_ov), .out_ready(b_or)
  );

  task automatic drive_a(input int sel, input logic [31:0] v);
    a_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    a_data[sel*32 +: 32] = v;
    a_sel = 2'(sel);
    a_iv  = 1'b1;
  endtask

  task automatic expect_a(input string tag, input logic [31:0] d, input int sel);
    check_eq({tag, "_vld"}, 64'(a_ov), 64'(1));
    check_eq({tag, "_data"}, 64'(a_od), 64'(d));
    check_eq({tag, "_sel"}, 64'(a_os), 64'(sel));
    check_eq({tag, "_err"}, 64'(a_oe), 64'(0));
  endtask

  // Random sweeps: each configuration runs its own reset and scoreboard.
  for (genvar g = 0; g < 3; g++) begin : sweep
    localparam int W  = (g == 0) ? 8  : (g == 1) ? 64 : 32;
    localparam int N  = (g == 0) ? 16 : (g == 1) ? 2  : 3;
    localparam int SW = $clog2(N);

    typedef struct {
      logic [W-1:0]  d;
      logic [SW-1:0] s;
      logic          e;
    } exp_t;

    logic          rst_r;
    logic [N*W-1:0] idata;
    logic [SW-1:0] isel, osel;
    logic          iv, ir, ov, ordy, oe;
    logic [W-1:0]  od;
    logic          done = 1'b0;

    result_mux_skid #(.WIDTH(W), .NUM_IN(N)) dut (
      .clk(clk), .rst(rst_r), .in_data(idata), .in_sel(isel), .in_valid(iv),
      .in_ready(ir), .out_data(od), .out_sel(osel), .out_err(oe),
      .out_valid(ov), .out_ready(ordy)
    );

    initial begin : stim
      exp_t           q[$];
      exp_t           e;
      logic [N*W-1:0] sh;
      int             si;
      logic           acc, xfer;
      rst_r = 1'b0;
      iv    = 1'b0;
      ordy  = 1'b0;
      idata = '0;
      isel  = '0;
      repeat (3) @(negedge clk);
      rst_r = 1'b1;
      @(negedge clk);
      for (int cyc = 0; cyc < 10000; cyc++) begin
        // Head of the queue is always what the output register must show.
        check_eq($sformatf("sw%0d_vld", g), 64'(ov), 64'(q.size() > 0));
        check_eq($sformatf("sw%0d_rdy", g), 64'(ir), 64'(q.size() < 2));
        if (ov && q.size() > 0) begin
          check_eq($sformatf("sw%0d_data", g), 64'(od), 64'(q[0].d));
          check_eq($sformatf("sw%0d_sel", g), 64'(osel), 64'(q[0].s));
          check_eq($sformatf("sw%0d_err", g), 64'(oe), 64'(q[0].e));
        end
        iv   = ($urandom_range(0, 9) < 7);
        ordy = ($urandom_range(0, 9) < 6);
        for (int b = 0; b < N*W; b += 32) idata[b +: 32] = $urandom();
        isel = SW'($urandom_range(0, (1 << SW) - 1));
        acc  = iv && ir;
        xfer = ov && ordy;
        if (xfer && q.size() > 0) void'(q.pop_front());
        if (acc) begin
          si  = int'(isel);
          e.e = (si >= N);
          sh  = idata >> (si * W);
          e.d = e.e ? '0 : sh[W-1:0];
          e.s = isel;
          q.push_back(e);
        end
        @(negedge clk);
      end
      iv   = 1'b0;
      done = 1'b1;
    end
  end

  initial begin
    rst0   = 1'b0;
    a_data = '0; a_sel = '0; a_iv = 1'b0; a_or = 1'b1;
    b_data = '0; b_sel = '0; b_iv = 1'b0; b_or = 1'b1;
    #1;
    check_eq("rst_vld", 64'(a_ov), 64'(0));
    check_eq("rst_data", 64'(a_od), 64'(0));
    check_eq("rst_sel", 64'(a_os), 64'(0));
    check_eq("rst_err", 64'(a_oe), 64'(0));
    repeat (2) @(negedge clk);
    check_eq("rst_rdy", 64'(a_ir), 64'(0));
    rst0 = 1'b1;
    #1 check_eq("rdy_pre_edge", 64'(a_ir), 64'(0));
    @(negedge clk);
    check_eq("rdy_after_edge", 64'(a_ir), 64'(1));

    // First beat: latency of one cycle
    drive_a(2, 32'hDEADBEEF);
    @(negedge clk);
    a_iv = 1'b0;
    expect_a("first", 32'hDEADBEEF, 2);
    @(negedge clk);
    check_eq("first_drain", 64'(a_ov), 64'(0));

    // Streaming without bubbles
    for (int i = 0; i < 8; i++) begin
      drive_a(i % 4, 32'h1000_0000 + 32'(i));
      @(negedge clk);
      expect_a($sformatf("stream%0d", i), 32'h1000_0000 + 32'(i), i % 4);
      check_eq($sformatf("stream%0d_rdy", i), 64'(a_ir), 64'(1));
    end
    a_iv = 1'b0;
    @(negedge clk);
    check_eq("stream_drain", 64'(a_ov), 64'(0));

    // Stall with A in output, B in skid, C held upstream
    a_or = 1'b0;
    drive_a(1, 32'hAAAA0001);
    @(negedge clk);
    expect_a("stallA", 32'hAAAA0001, 1);
    check_eq("stallA_rdy", 64'(a_ir), 64'(1));
    drive_a(3, 32'hBBBB0003);
    @(negedge clk);
    expect_a("stallB_hold", 32'hAAAA0001, 1);
    check_eq("stallB_rdy", 64'(a_ir), 64'(0));
    drive_a(0, 32'hCCCC0000);
    @(negedge clk);
    expect_a("stallC_hold", 32'hAAAA0001, 1);
    check_eq("stallC_rdy", 64'(a_ir), 64'(0));
    a_or = 1'b1;
    @(negedge clk);
    expect_a("drainB", 32'hBBBB0003, 3);
    check_eq("drainB_rdy", 64'(a_ir), 64'(1));
    @(negedge clk);
    a_iv = 1'b0;
    expect_a("drainC", 32'hCCCC0000, 0);
    @(negedge clk);
    check_eq("drain_empty", 64'(a_ov), 64'(0));

    // Out-of-range select on the 3-way block
    b_data = {$urandom(), $urandom(), $urandom()};
    b_sel  = 2'd3;
    b_iv   = 1'b1;
    @(negedge clk);
    check_eq("oor_vld", 64'(b_ov), 64'(1));
    check_eq("oor_data", 64'(b_od), 64'(0));
    check_eq("oor_err", 64'(b_oe), 64'(1));
    check_eq("oor_sel", 64'(b_os), 64'(3));
    b_data = {$urandom(), 32'h12345678, $urandom()};
    b_sel  = 2'd1;
    @(negedge clk);
    b_iv = 1'b0;
    check_eq("inr_vld", 64'(b_ov), 64'(1));
    check_eq("inr_data", 64'(b_od), 64'(32'h12345678));
    check_eq("inr_err", 64'(b_oe), 64'(0));
    check_eq("inr_sel", 64'(b_os), 64'(1));

    // Asynchronous reset while stalled with the skid full
    a_or = 1'b0;
    drive_a(2, 32'hD00D0002);
    @(negedge clk);
    drive_a(1, 32'hE00E0001);
    @(negedge clk);
    a_iv = 1'b0;
    check_eq("full_vld", 64'(a_ov), 64'(1));
    check_eq("full_rdy", 64'(a_ir), 64'(0));
    #2 rst0 = 1'b0;
    #1;
    check_eq("arst_vld", 64'(a_ov), 64'(0));
    check_eq("arst_data", 64'(a_od), 64'(0));
    check_eq("arst_sel", 64'(a_os), 64'(0));
    check_eq("arst_err", 64'(a_oe), 64'(0));
    check_eq("arst_rdy", 64'(a_ir), 64'(0));
    @(negedge clk);
    rst0 = 1'b1;
    a_or = 1'b1;
    @(negedge clk);
    check_eq("post_rst_rdy", 64'(a_ir), 64'(1));
    check_eq("post_rst_vld0", 64'(a_ov), 64'(0));
    @(negedge clk);
    check_eq("post_rst_vld1", 64'(a_ov), 64'(0));

    for (int c = 0; c < 30000; c++) begin
      if (sweep[0].done && sweep[1].done && sweep[2].done) break;
      @(negedge clk);
    end
    check_eq("sweep_done", 64'(sweep[0].done && sweep[1].done && sweep[2].done), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
